minon_cpu: RTL and testbench

//  Self-contained 5-stage in-order RV32-style integer core (IF/ID/EX/MEM/WB) for bring-up.

---
 rtl/minon_cpu_pkg.sv | 75 +++++++
 rtl/minon_alu.sv | 27 ++
 rtl/minon_cpu.sv | 83 ++++++++
 tb/tb_minon_cpu.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/minon_cpu_pkg.sv
// minon_cpu_pkg: shared types and constants for the minon_cpu core
// Holds encoding constants, the ALU op enum, register and pipeline-stage structs,
// the bit-reversed R-type decoder and the register-match helper used for hazards.
package minon_cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] OPC_ALU = 7'b1100110;
  localparam logic [6:0] F7_ALT = 7'b0000010;
  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SLL = 3'd1;
  localparam logic [2:0] F3_SLT = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR = 3'd4;
  localparam logic [2:0] F3_SR = 3'd5;
  localparam logic [2:0] F3_OR = 3'd6;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;
  typedef struct packed {
    logic [XLEN-1:0] data;
  } reg_t;
  // we is only set for real ALU ops with rd != 0, so x0 never writes or forwards
  typedef struct packed {
    logic we;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    alu_op_e op;
  } dec_t;
  typedef struct packed {
    logic valid;
    logic [31:0] instr;
  } ifid_t;
  typedef struct packed {
    logic valid;
    dec_t dec;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } idex_t;
  typedef struct packed {
    logic valid;
    logic we;
    logic [4:0] rd;
    logic [XLEN-1:0] res;
  } exmem_t;
  typedef struct packed {
    logic valid;
    logic we;
    logic [4:0] rd;
    logic [XLEN-1:0] res;
  } memwb_t;
  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    logic alt;
    alt = i[6:0] == F7_ALT;
    d.we = i[31:25] == OPC_ALU && i[24:20] != 5'd0;
    d.rd = i[24:20];
    d.rs1 = i[16:12];
    d.rs2 = i[11:7];
    case (i[19:17])
      F3_ADD: d.op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL: d.op = ALU_SLL;
      F3_SLT: d.op = ALU_SLT;
      F3_SLTU: d.op = ALU_SLTU;
      F3_XOR: d.op = ALU_XOR;
      F3_SR: d.op = alt ? ALU_SRA : ALU_SRL;
      F3_OR: d.op = ALU_OR;
      default: d.op = ALU_AND;
    endcase
    return d;
  endfunction
  function automatic logic hit(input logic v, input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return v && we && rd == rs;
  endfunction
endpackage

// File: rtl/minon_alu.sv
// minon_alu: combinational integer ALU
// Ports: op (alu_op_e), a/b operands (XLEN) -> y result (XLEN). Shifts use b[4:0].
module minon_alu
  import minon_cpu_pkg::*;
(
  input alu_op_e op,
  input logic [XLEN-1:0] a,
  input logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLL: y = a << b[4:0];
      ALU_SLT: y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR: y = a ^ b;
      ALU_SRL: y = a >> b[4:0];
      ALU_SRA: y = $signed(a) >>> b[4:0];
      ALU_OR: y = a | b;
      ALU_AND: y = a & b;
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/minon_cpu.sv
// minon_cpu: 5-stage in-order RV32-style R-type core (IF/ID/EX/MEM/WB), no external bus
// Ports: CLOCK_50 (rising-edge clock), RSTN_N (async active-low reset).
// instCache and regs are preloaded hierarchically; reset clears pc and pipeline valids only.
// Define CPU_FWD_EN for EX/MEM and MEM/WB -> EX forwarding; otherwise ID interlocks on RAW.
module minon_cpu
  import minon_cpu_pkg::*;
#(
  parameter int IMEM_WORDS = 32
) (
  input logic CLOCK_50,
  input logic RSTN_N
);
  localparam int PW = $clog2(IMEM_WORDS);
  logic [31:0] instCache [0:IMEM_WORDS-1] = '{default: '0};
  reg_t regs [0:31];
  logic [PW-1:0] pc_q = '0;
  logic [PW-1:0] pc_d;
  ifid_t ifid_q = '0;
  ifid_t ifid_d;
  idex_t idex_q = '0;
  idex_t idex_d;
  exmem_t exmem_q = '0;
  exmem_t exmem_d;
  memwb_t memwb_q = '0;
  memwb_t memwb_d;
  dec_t dec;
  logic stall;
  logic [XLEN-1:0] rs1_v, rs2_v, ex_a, ex_b, op_a, op_b, alu_y;
  assign dec = decode(ifid_q.instr);
  // WB write-through: an ID read of the register being written this edge sees the new value
  assign rs1_v = hit(memwb_q.valid, memwb_q.we, memwb_q.rd, dec.rs1) ? memwb_q.res : regs[dec.rs1].data;
  assign rs2_v = hit(memwb_q.valid, memwb_q.we, memwb_q.rd, dec.rs2) ? memwb_q.res : regs[dec.rs2].data;
`ifdef CPU_FWD_EN
  assign stall = 1'b0;
  assign ex_a = hit(exmem_q.valid, exmem_q.we, exmem_q.rd, idex_q.dec.rs1) ? exmem_q.res :
                hit(memwb_q.valid, memwb_q.we, memwb_q.rd, idex_q.dec.rs1) ? memwb_q.res : idex_q.a;
  assign ex_b = hit(exmem_q.valid, exmem_q.we, exmem_q.rd, idex_q.dec.rs2) ? exmem_q.res :
                hit(memwb_q.valid, memwb_q.we, memwb_q.rd, idex_q.dec.rs2) ? memwb_q.res : idex_q.b;
`else
  // producers already in MEM/WB are covered by write-through, so only EX and MEM interlock
  assign stall = ifid_q.valid && dec.we &&
                 (hit(idex_q.valid, idex_q.dec.we, idex_q.dec.rd, dec.rs1) ||
                  hit(idex_q.valid, idex_q.dec.we, idex_q.dec.rd, dec.rs2) ||
                  hit(exmem_q.valid, exmem_q.we, exmem_q.rd, dec.rs1) ||
                  hit(exmem_q.valid, exmem_q.we, exmem_q.rd, dec.rs2));
  assign ex_a = idex_q.a;
  assign ex_b = idex_q.b;
`endif
  // x0 is forced to zero here so a preloaded non-zero regs[0] never leaks into results
  assign op_a = idex_q.dec.rs1 == 5'd0 ? '0 : ex_a;
  assign op_b = idex_q.dec.rs2 == 5'd0 ? '0 : ex_b;
  minon_alu u_alu (
    .op(idex_q.dec.op),
    .a(op_a),
    .b(op_b),
    .y(alu_y)
  );
  always_comb begin
    pc_d = stall ? pc_q : (pc_q == PW'(IMEM_WORDS - 1) ? '0 : pc_q + 1'b1);
    ifid_d = stall ? ifid_q : ifid_t'{1'b1, instCache[pc_q]};
    idex_d = idex_t'{ifid_q.valid && !stall, dec, rs1_v, rs2_v};
    exmem_d = exmem_t'{idex_q.valid, idex_q.dec.we, idex_q.dec.rd, alu_y};
    memwb_d = memwb_t'{exmem_q.valid, exmem_q.we, exmem_q.rd, exmem_q.res};
  end
  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      pc_q <= '0;
      ifid_q <= '0;
      idex_q <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      pc_q <= pc_d;
      ifid_q <= ifid_d;
      idex_q <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (memwb_q.valid && memwb_q.we) regs[memwb_q.rd].data <= memwb_q.res;
  end
endmodule

// File: tb/tb_minon_cpu.sv
// tb_minon_cpu: table-driven program checks plus a writeback scoreboard for minon_cpu
module tb_minon_cpu;
  typedef struct packed {
    logic [4:0] base;
    logic [2:0][31:0] prog;
    logic [7:0][31:0] init;
    logic [7:0][31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  int checks = 0;
  int errors = 0;
  int edges = 0;
  int start = 0;
  int first_wb = -1;
  int exp_first = 0;
  logic [36:0] exp_q[$];
  vec_t vecs [6];
  minon_cpu dut (
    .CLOCK_50(clk),
    .RSTN_N(rstn)
  );
  always #100 clk = ~clk;
  always @(posedge clk) edges++;
  function automatic logic [31:0] rt(input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b1100110, rd, f3, rs1, rs2, f7};
  endfunction
  function automatic logic [37:0] exec(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic alt;
    alt = i[6:0] == 7'b0000010;
    case (i[19:17])
      3'd0: r = alt ? a - b : a + b;
      3'd1: r = a << b[4:0];
      3'd2: r = {31'd0, $signed(a) < $signed(b)};
      3'd3: r = {31'd0, a < b};
      3'd4: r = a ^ b;
      3'd5: if (alt) r = $signed(a) >>> b[4:0]; else r = a >> b[4:0];
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return {i[31:25] == 7'b1100110 && i[24:20] != 5'd0, i[24:20], r};
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask
  always @(negedge clk) begin
    if (dut.memwb_q.valid && dut.memwb_q.we) begin
      logic [36:0] got, e;
      got = {dut.memwb_q.rd, dut.memwb_q.res};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_extra got rd=%0d val=%h want none", got[36:32], got[31:0]);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL wb_order got rd=%0d val=%h want rd=%0d val=%h", got[36:32], got[31:0], e[36:32], e[31:0]);
        end
      end
      if (first_wb < 0) first_wb = edges - start + 1;
    end
  end
  task automatic load(input vec_t v);
    logic [31:0] mr [32];
    logic [37:0] r;
    for (int i = 0; i < 32; i++) begin
      mr[i] = i < 8 ? v.init[i] : 32'd0;
      dut.instCache[i] = 32'd0;
      dut.regs[i].data = mr[i];
    end
    exp_q.delete();
    exp_first = 0;
    first_wb = -1;
    for (int j = 0; j < 3; j++) begin
      dut.instCache[v.base + j] = v.prog[j];
      r = exec(v.prog[j], mr[v.prog[j][16:12]], mr[v.prog[j][11:7]]);
      if (r[37]) begin
        exp_q.push_back(r[36:0]);
        mr[r[36:32]] = r[31:0];
        if (exp_first == 0) exp_first = v.base + j + 5;
      end
    end
  endtask
  task automatic restart(input vec_t v);
    @(negedge clk);
    rstn = 1'b0;
    load(v);
    @(negedge clk);
    rstn = 1'b1;
    start = edges;
  endtask
  task automatic run_check(input vec_t v, input string tag);
    repeat (20) @(posedge clk);
    @(negedge clk);
    for (int r = 0; r < 8; r++) chk($sformatf("%s_x%0d", tag, r), dut.regs[r].data, v.exp[r]);
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    if (exp_first != 0) chk({tag, "_latency"}, 32'(first_wb), 32'(exp_first));
  endtask
  initial begin
    vec_t v;
    logic [31:0] add111;
    add111 = rt(3'd0, 7'd0, 5'd1, 5'd1, 5'd1);
    v = '0; v.base = 5'd3; v.prog = {add111, add111, add111};
    v.init[1] = 32'd1; v.exp = v.init; v.exp[1] = 32'd8; vecs[0] = v;
    v.base = 5'd2; vecs[1] = v;
    v = '0;
    v.prog[0] = rt(3'd0, 7'b0000010, 5'd4, 5'd2, 5'd3);
    v.prog[1] = rt(3'd2, 7'd0, 5'd5, 5'd4, 5'd0);
    v.prog[2] = rt(3'd5, 7'b0000010, 5'd6, 5'd4, 5'd2);
    v.init[2] = 32'd5; v.init[3] = 32'd7; v.exp = v.init;
    v.exp[4] = 32'hFFFFFFFE; v.exp[5] = 32'd1; v.exp[6] = 32'hFFFFFFFF; vecs[2] = v;
    v = '0; v.base = 5'd1;
    v.prog[0] = rt(3'd0, 7'd0, 5'd0, 5'd1, 5'd1);
    v.prog[1] = rt(3'd0, 7'd0, 5'd7, 5'd0, 5'd1);
    v.init[1] = 32'd3; v.exp = v.init; v.exp[7] = 32'd3; vecs[3] = v;
    v = '0; v.base = 5'd5;
    v.prog[0] = rt(3'd6, 7'd0, 5'd4, 5'd2, 5'd3);
    v.prog[1] = rt(3'd7, 7'd0, 5'd5, 5'd2, 5'd3);
    v.prog[2] = rt(3'd4, 7'd0, 5'd6, 5'd2, 5'd3);
    v.init[2] = 32'd5; v.init[3] = 32'd7; v.exp = v.init;
    v.exp[4] = 32'd7; v.exp[5] = 32'd5; v.exp[6] = 32'd2; vecs[4] = v;
    v = '0; v.base = 5'd0;
    v.prog[0] = rt(3'd5, 7'd0, 5'd4, 5'd2, 5'd3);
    v.prog[1] = rt(3'd3, 7'd0, 5'd5, 5'd3, 5'd2);
    v.prog[2] = rt(3'd1, 7'd0, 5'd6, 5'd3, 5'd3);
    v.init[2] = 32'hFFFFFFF0; v.init[3] = 32'd4; v.exp = v.init;
    v.exp[4] = 32'h0FFFFFFF; v.exp[5] = 32'd1; v.exp[6] = 32'h40; vecs[5] = v;
    load(vecs[0]);
    start = 0;
    run_check(vecs[0], "add_at3");
    for (int i = 1; i < 6; i++) begin
      restart(vecs[i]);
      run_check(vecs[i], $sformatf("vec%0d", i));
    end
    v = '0;
    for (int i = 1; i < 8; i++) v.init[i] = 32'h1000 + i;
    v.exp = v.init;
    restart(v);
    repeat (31) @(posedge clk);
    @(negedge clk);
    chk("nop_pc31", 32'(dut.pc_q), 32'd31);
    @(posedge clk);
    @(negedge clk);
    chk("nop_pc_wrap", 32'(dut.pc_q), 32'd0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("nop_pc40", 32'(dut.pc_q), 32'd8);
    for (int r = 0; r < 8; r++) chk($sformatf("nop_x%0d", r), dut.regs[r].data, v.exp[r]);
    v = vecs[0];
    v.base = 5'd0;
    restart(v);
    repeat (2) @(posedge clk);
    #50 rstn = 1'b0;
    #1;
    chk("rst_pc", 32'(dut.pc_q), 32'd0);
    chk("rst_valid", {28'd0, dut.ifid_q.valid, dut.idex_q.valid, dut.exmem_q.valid, dut.memwb_q.valid}, 32'd0);
    chk("rst_x1_hold", dut.regs[1].data, 32'd1);
    #99 rstn = 1'b1;
    start = edges;
    first_wb = -1;
    run_check(v, "midrst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
